vtg_param: RTL and testbench
============================

# vtg_param

Parametrised video timing generator for core-side video paths. It generalises the fixed-mode timing logic in our demo cores:
- all horizontal and vertical totals, blank and sync positions are run-time inputs, latched only at a frame boundary;
- a programmable pixel clock-enable divider;
- pixel/line counters, a frame-start strobe and a free-running frame counter for animation.

It sits between the core clock domain and the pixel-generation logic, feeding the MiSTer video output path.

## Interface
Parameters:
- CW, 11, width of h/v counters and timing inputs
- DW, 3, width of clock-enable divider setting
- FW, 8, frame counter width
- H_TOTAL_D / H_BLANK_D / H_SYNC_S_D / H_SYNC_E_D, 637 / 529 / 544 / 590, reset defaults for horizontal shadow registers
- V_TOTAL_D / V_BLANK_D / V_SYNC_S_D / V_SYNC_E_D, 261 / 240 / 245 / 248, reset defaults for vertical shadow registers
- CE_DIV_D, 1, reset default divider

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- h_total, h_blank, h_sync_s, h_sync_e  in  CW each  last pixel index, first blanked pixel, first/first-after sync pixel
- v_total, v_blank, v_sync_s, v_sync_e  in  CW each  same for lines
- ce_div  in  DW  ce_pix asserted once every ce_div+1 clocks
- ce_pix  out  1  pixel clock enable
- hc, vc  out  CW  current pixel / line
- hblank, hsync, vblank, vsync  out  1  active-high
- frame_start  out  1  one-clk strobe at counter wrap to (0,0)
- frame_cnt  out  FW  frames since reset, wraps

## Operation
- Shadow registers: all eight timing inputs and ce_div are held in shadow registers. Reset loads the *_D parameters.
- Shadow update: shadows copy the inputs only on the ce_pix clock where hc==h_total and vc==v_total (the wrap). Input changes mid-frame have no effect until the next wrap.
- Divider: a DW-bit counter counts 0..ce_div_shadow. ce_pix is a registered output, 1 on the clock after the counter equals ce_div_shadow, otherwise 0.
  - ce_div_shadow=0 gives ce_pix constantly 1.
  - The divider counter restarts at 0 on the wrap clock.
- Counters: advance only on clocks with ce_pix=1.
  - hc increments; at hc==h_total, hc goes to 0 and vc increments.
  - At vc==v_total together with hc==h_total, vc goes to 0.
  - All comparisons are equality against shadows, evaluated before the shadow update on that same clock.
- Decodes: registered from hc/vc, so they lag the counters by one clk.
  - hblank = (hc >= h_blank) or (hc > h_total)
  - hsync = h_sync_s <= hc < h_sync_e
  - vblank = vc >= v_blank
  - vsync = v_sync_s <= vc < v_sync_e
- Degenerate settings:
  - h_blank > h_total: hblank never asserts.
  - h_sync_e <= h_sync_s: hsync never asserts.
  - Vertical decodes behave the same way.
  - No error is flagged in any of these cases.
- frame_start / frame_cnt: frame_start pulses 1 for exactly one clk, the clk after the wrap. frame_cnt increments at the wrap and wraps modulo 2^FW.

## Timing
- Reset values:
  - ce_pix=0, hc=0, vc=0, frame_cnt=0
  - hblank=0, hsync=0, vblank=0, vsync=0, frame_start=0
  - divider counter 0, shadows = *_D
- First ce_pix: asserts CE_DIV_D+1 clocks after reset deassertion.
- Counter latency: hc/vc change on the clock edge where ce_pix is sampled 1. Decodes reflect the new counters one clk later.
- Reset mid-frame: asserting reset forces all outputs to their reset values immediately (asynchronous). On release, the frame restarts at (0,0) with default timing; pending input changes are not latched until the first wrap.
- Simultaneous input change and wrap on the same clock: the new input value is captured.
- Line period = (h_total+1)*(ce_div+1) clocks. Frame period = (v_total+1) × line period.

## Structure
- Shared package `vtg_pkg` holds:
  - the default timing constants (NTSC 240p and PAL 288p sets);
  - the CW/DW/FW defaults.
- One sub-module, `vtg_cediv`: divider counter with restart input, producing ce_pix.
- Counters, shadows and decodes stay in `vtg_param`.

## Test plan
- Reset defaults:
  - Every 2 clocks a ce_pix.
  - hblank rises when hc==529 (one clk late) and falls after hc==0.
  - hsync is high for 46 pixels.
  - Frame is 638×262 pixels = 334312 clocks.
- ce_div=0 with PAL values (v_total=311, v_blank=288, v_sync 304..308):
  - ce_pix is constantly 1 after the first wrap.
  - vsync is high for 4 lines; frame_start period is 638×312 clocks.
- Mid-frame change: write h_total=799 at vc=100 → line length stays 638 until the wrap; the next frame has 800-pixel lines.
- Asynchronous reset at hc=300, vc=120:
  - All outputs clear in the same clk.
  - After release, hc restarts at 0 and defaults apply.
- Degenerate: h_sync_e=h_sync_s=544 → hsync stays 0 for a full frame; other outputs are unaffected.
- Frame counter: with FW=8, run 257 frames → frame_cnt reads 1, with 257 frame_start pulses each one clk wide.

Source files
------------

// File: rtl/vtg_pkg.sv
// Shared constants for the video timing generator.
// Default widths plus NTSC 240p and PAL 288p timing sets.
package vtg_pkg;

  localparam int CW_DEF = 11;
  localparam int DW_DEF = 3;
  localparam int FW_DEF = 8;

  localparam int CE_DIV_DEF = 1;

  // NTSC 240p
  localparam int NTSC_H_TOTAL  = 637;
  localparam int NTSC_H_BLANK  = 529;
  localparam int NTSC_H_SYNC_S = 544;
  localparam int NTSC_H_SYNC_E = 590;
  localparam int NTSC_V_TOTAL  = 261;
  localparam int NTSC_V_BLANK  = 240;
  localparam int NTSC_V_SYNC_S = 245;
  localparam int NTSC_V_SYNC_E = 248;

  // PAL 288p
  localparam int PAL_H_TOTAL  = 637;
  localparam int PAL_H_BLANK  = 529;
  localparam int PAL_H_SYNC_S = 544;
  localparam int PAL_H_SYNC_E = 590;
  localparam int PAL_V_TOTAL  = 311;
  localparam int PAL_V_BLANK  = 288;
  localparam int PAL_V_SYNC_S = 304;
  localparam int PAL_V_SYNC_E = 308;

endpackage

// File: rtl/vtg_cediv.sv
// Pixel clock-enable divider: ce_pix once every div+1 clocks.
// Ports: clk, reset, restart (treat count as 0 now), div, ce_pix.
module vtg_cediv
  import vtg_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          restart,
  input  logic [DW-1:0] div,
  output logic          ce_pix
);

  logic [DW-1:0] cnt_q, cnt_d, cnt_cur;
  logic          ce_q, ce_d;

  // On restart the step is taken from a count of 0 so a
  // steady-state frame keeps its exact period.
  always_comb begin
    cnt_cur = restart ? '0 : cnt_q;
    ce_d    = (cnt_cur == div);
    cnt_d   = ce_d ? '0 : cnt_cur + DW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ce_q  <= ce_d;
    end
  end

  assign ce_pix = ce_q;

endmodule

// File: rtl/vtg_param.sv
// Run-time programmable video timing generator.
// Ports: clk, reset, timing inputs, ce_div -> ce_pix, hc/vc, syncs, blanks, frame strobe/count.
module vtg_param
  import vtg_pkg::*;
#(
  parameter int CW         = CW_DEF,
  parameter int DW         = DW_DEF,
  parameter int FW         = FW_DEF,
  parameter int H_TOTAL_D  = NTSC_H_TOTAL,
  parameter int H_BLANK_D  = NTSC_H_BLANK,
  parameter int H_SYNC_S_D = NTSC_H_SYNC_S,
  parameter int H_SYNC_E_D = NTSC_H_SYNC_E,
  parameter int V_TOTAL_D  = NTSC_V_TOTAL,
  parameter int V_BLANK_D  = NTSC_V_BLANK,
  parameter int V_SYNC_S_D = NTSC_V_SYNC_S,
  parameter int V_SYNC_E_D = NTSC_V_SYNC_E,
  parameter int CE_DIV_D   = CE_DIV_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] h_total,
  input  logic [CW-1:0] h_blank,
  input  logic [CW-1:0] h_sync_s,
  input  logic [CW-1:0] h_sync_e,
  input  logic [CW-1:0] v_total,
  input  logic [CW-1:0] v_blank,
  input  logic [CW-1:0] v_sync_s,
  input  logic [CW-1:0] v_sync_e,
  input  logic [DW-1:0] ce_div,
  output logic          ce_pix,
  output logic [CW-1:0] hc,
  output logic [CW-1:0] vc,
  output logic          hblank,
  output logic          hsync,
  output logic          vblank,
  output logic          vsync,
  output logic          frame_start,
  output logic [FW-1:0] frame_cnt
);

  logic [CW-1:0] ht_q, hb_q, hss_q, hse_q;
  logic [CW-1:0] vt_q, vb_q, vss_q, vse_q;
  logic [CW-1:0] ht_d, hb_d, hss_d, hse_d;
  logic [CW-1:0] vt_d, vb_d, vss_d, vse_d;
  logic [DW-1:0] div_q, div_d, div_eff;
  logic [CW-1:0] hc_q, hc_d, vc_q, vc_d;
  logic          hblank_q, hblank_d, hsync_q, hsync_d;
  logic          vblank_q, vblank_d, vsync_q, vsync_d;
  logic          fs_q, fs_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          ce, h_end, v_end, wrap;

  // The new divider takes effect on the wrap clock itself.
  assign div_eff = wrap ? ce_div : div_q;

  vtg_cediv #(.DW(DW)) u_cediv (
    .clk    (clk),
    .reset  (reset),
    .restart(wrap),
    .div    (div_eff),
    .ce_pix (ce)
  );

  always_comb begin
    h_end = (hc_q == ht_q);
    v_end = (vc_q == vt_q);
    wrap  = ce && h_end && v_end;

    ht_d  = ht_q;  hb_d  = hb_q;
    hss_d = hss_q; hse_d = hse_q;
    vt_d  = vt_q;  vb_d  = vb_q;
    vss_d = vss_q; vse_d = vse_q;
    div_d = div_q;
    if (wrap) begin
      ht_d  = h_total;  hb_d  = h_blank;
      hss_d = h_sync_s; hse_d = h_sync_e;
      vt_d  = v_total;  vb_d  = v_blank;
      vss_d = v_sync_s; vse_d = v_sync_e;
      div_d = ce_div;
    end

    hc_d = hc_q;
    vc_d = vc_q;
    if (ce) begin
      if (h_end) begin
        hc_d = '0;
        vc_d = v_end ? '0 : vc_q + CW'(1);
      end else begin
        hc_d = hc_q + CW'(1);
      end
    end

    hblank_d = (hc_q >= hb_q) || (hc_q > ht_q);
    hsync_d  = (hc_q >= hss_q) && (hc_q < hse_q);
    vblank_d = (vc_q >= vb_q);
    vsync_d  = (vc_q >= vss_q) && (vc_q < vse_q);

    fs_d   = wrap;
    fcnt_d = fcnt_q + FW'(wrap);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ht_q     <= CW'(H_TOTAL_D);
      hb_q     <= CW'(H_BLANK_D);
      hss_q    <= CW'(H_SYNC_S_D);
      hse_q    <= CW'(H_SYNC_E_D);
      vt_q     <= CW'(V_TOTAL_D);
      vb_q     <= CW'(V_BLANK_D);
      vss_q    <= CW'(V_SYNC_S_D);
      vse_q    <= CW'(V_SYNC_E_D);
      div_q    <= DW'(CE_DIV_D);
      hc_q     <= '0;
      vc_q     <= '0;
      hblank_q <= 1'b0;
      hsync_q  <= 1'b0;
      vblank_q <= 1'b0;
      vsync_q  <= 1'b0;
      fs_q     <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      ht_q     <= ht_d;
      hb_q     <= hb_d;
      hss_q    <= hss_d;
      hse_q    <= hse_d;
      vt_q     <= vt_d;
      vb_q     <= vb_d;
      vss_q    <= vss_d;
      vse_q    <= vse_d;
      div_q    <= div_d;
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      hblank_q <= hblank_d;
      hsync_q  <= hsync_d;
      vblank_q <= vblank_d;
      vsync_q  <= vsync_d;
      fs_q     <= fs_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign ce_pix      = ce;
  assign hc          = hc_q;
  assign vc          = vc_q;
  assign hblank      = hblank_q;
  assign hsync       = hsync_q;
  assign vblank      = vblank_q;
  assign vsync       = vsync_q;
  assign frame_start = fs_q;
  assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_vtg_param.sv
// Bench for vtg_param with a small default timing set.
// Expected values are queued with the stimulus and popped per measurement.
module tb_vtg_param;

  localparam int CW = 11;
  localparam int DW = 3;
  localparam int FW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] h_total, h_blank, h_sync_s, h_sync_e;
  logic [CW-1:0] v_total, v_blank, v_sync_s, v_sync_e;
  logic [DW-1:0] ce_div;
  logic          ce_pix, hblank, hsync, vblank, vsync, frame_start;
  logic [CW-1:0] hc, vc;
  logic [FW-1:0] frame_cnt;

  int n_chk = 0;
  int n_pass = 0;
  int sb_exp[$];
  string sb_tag[$];

  vtg_param #(
    .CW(CW), .DW(DW), .FW(FW),
    .H_TOTAL_D(19), .H_BLANK_D(15),
    .H_SYNC_S_D(16), .H_SYNC_E_D(18),
    .V_TOTAL_D(11), .V_BLANK_D(9),
    .V_SYNC_S_D(10), .V_SYNC_E_D(11),
    .CE_DIV_D(1)
  ) dut (
    .clk(clk), .reset(reset),
    .h_total(h_total), .h_blank(h_blank),
    .h_sync_s(h_sync_s), .h_sync_e(h_sync_e),
    .v_total(v_total), .v_blank(v_blank),
    .v_sync_s(v_sync_s), .v_sync_e(v_sync_e),
    .ce_div(ce_div), .ce_pix(ce_pix),
    .hc(hc), .vc(vc),
    .hblank(hblank), .hsync(hsync),
    .vblank(vblank), .vsync(vsync),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic push_exp(input string tag, input int v);
    sb_tag.push_back(tag);
    sb_exp.push_back(v);
  endtask

  task automatic sb_pop(input int got);
    if (sb_exp.size() == 0) check("sb_underflow", 0, 1);
    else check(sb_tag.pop_front(), got, sb_exp.pop_front());
  endtask

  function automatic logic sel(input int s);
    case (s)
      0: return ce_pix;
      1: return hblank;
      2: return hsync;
      3: return vblank;
      4: return vsync;
      5: return frame_start;
      default: return (hc == '0);
    endcase
  endfunction

  task automatic wait_lvl(input int s, input logic v, input int bound, output int n);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (sel(s) == v) begin n = i; break; end
    end
  endtask

  task automatic wait_rise(input int s, input int bound, output int n);
    logic prev;
    prev = sel(s);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (sel(s) && !prev) begin n = i; break; end
      prev = sel(s);
    end
  endtask

  task automatic meas_gap(input int s, input int bound, output int g);
    int n;
    wait_rise(s, bound, n);
    if (n < 0) g = -1;
    else wait_rise(s, bound, g);
  endtask

  task automatic meas_width(input int s, input int bound, output int w);
    int n;
    wait_rise(s, bound, n);
    w = -1;
    if (n >= 0) begin
      w = 1;
      for (int i = 0; i < bound; i++) begin
        @(negedge clk);
        if (!sel(s)) break;
        w++;
      end
    end
  endtask

  task automatic count_hi(input int s, input int nclk, output int c);
    c = 0;
    for (int i = 0; i < nclk; i++) begin
      @(negedge clk);
      if (sel(s)) c++;
    end
  endtask

  task automatic wait_hv(input int h, input int v, input int bound, output int n);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (int'(hc) == h && (v < 0 || int'(vc) == v)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic set_h(input int t, input int b, input int s, input int e);
    h_total = CW'(t); h_blank = CW'(b);
    h_sync_s = CW'(s); h_sync_e = CW'(e);
  endtask

  task automatic set_v(input int t, input int b, input int s, input int e);
    v_total = CW'(t); v_blank = CW'(b);
    v_sync_s = CW'(s); v_sync_e = CW'(e);
  endtask

  task automatic push_zero_outs();
    push_exp("rst_ce_pix", 0);
    push_exp("rst_hc", 0);
    push_exp("rst_vc", 0);
    push_exp("rst_hblank", 0);
    push_exp("rst_hsync", 0);
    push_exp("rst_vblank", 0);
    push_exp("rst_vsync", 0);
    push_exp("rst_frame_start", 0);
    push_exp("rst_frame_cnt", 0);
  endtask

  task automatic pop_outs();
    sb_pop(int'(ce_pix));
    sb_pop(int'(hc));
    sb_pop(int'(vc));
    sb_pop(int'(hblank));
    sb_pop(int'(hsync));
    sb_pop(int'(vblank));
    sb_pop(int'(vsync));
    sb_pop(int'(frame_start));
    sb_pop(int'(frame_cnt));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, p1, p2, first_ce, pulses, bad, fcnt;
    logic prev;

    set_h(19, 15, 16, 18);
    set_v(11, 9, 10, 11);
    ce_div = 3'd1;

    push_zero_outs();
    repeat (3) @(negedge clk);
    pop_outs();

    push_exp("first_ce", 2);
    push_exp("ce_gap", 2);
    reset = 1'b0;
    wait_lvl(0, 1'b1, 20, n);
    sb_pop(n);
    wait_rise(0, 20, n);
    sb_pop(n);

    push_exp("hblank_rise_lag", 1);
    push_exp("hblank_fall_lag", 1);
    push_exp("hsync_w", 4);
    push_exp("hblank_w", 10);
    push_exp("vsync_w", 40);
    push_exp("vblank_w", 120);
    push_exp("frame_gap_def", 480);
    wait_hv(14, -1, 100, n);
    wait_hv(15, -1, 100, n);
    wait_lvl(1, 1'b1, 10, n);
    sb_pop(n);
    wait_hv(19, -1, 100, n);
    wait_hv(0, -1, 100, n);
    wait_lvl(1, 1'b0, 10, n);
    sb_pop(n);
    meas_width(2, 200, n);
    sb_pop(n);
    meas_width(1, 200, n);
    sb_pop(n);
    meas_width(4, 2000, n);
    sb_pop(n);
    meas_width(3, 2000, n);
    sb_pop(n);
    meas_gap(5, 2000, n);
    sb_pop(n);

    set_v(14, 11, 12, 14);
    ce_div = 3'd0;
    push_exp("ce_const", 50);
    push_exp("frame_gap_div0", 300);
    push_exp("vsync_w_div0", 40);
    push_exp("vblank_w_div0", 80);
    wait_rise(5, 2000, n);
    count_hi(0, 50, n);
    sb_pop(n);
    meas_gap(5, 2000, n);
    sb_pop(n);
    meas_width(4, 2000, n);
    sb_pop(n);
    meas_width(3, 2000, n);
    sb_pop(n);

    wait_hv(0, 5, 2000, n);
    h_total = CW'(29);
    push_exp("line_before_wrap", 20);
    push_exp("line_after_wrap", 30);
    push_exp("frame_gap_h29", 450);
    meas_gap(6, 200, n);
    sb_pop(n);
    wait_rise(5, 2000, n);
    wait_rise(6, 200, n);
    wait_rise(6, 200, n);
    sb_pop(n);
    meas_gap(5, 2000, n);
    sb_pop(n);

    h_sync_s = CW'(16);
    h_sync_e = CW'(16);
    push_exp("hsync_degen", 0);
    push_exp("hblank_cnt", 225);
    push_exp("vsync_cnt", 60);
    push_exp("vblank_cnt", 120);
    wait_rise(5, 2000, n);
    count_hi(2, 450, n);
    sb_pop(n);
    count_hi(1, 450, n);
    sb_pop(n);
    count_hi(4, 450, n);
    sb_pop(n);
    count_hi(3, 450, n);
    sb_pop(n);

    push_exp("pre_rst_hc", 10);
    wait_hv(10, 6, 2000, n);
    sb_pop(int'(hc));
    push_zero_outs();
    #2;
    reset = 1'b1;
    #1;
    pop_outs();

    set_h(3, 2, 2, 3);
    set_v(1, 1, 1, 2);
    ce_div = 3'd0;
    push_exp("post_rst_first_ce", 2);
    push_exp("post_rst_first_fs", 481);
    push_exp("small_frame_gap", 8);
    push_exp("fs_pulses", 257);
    push_exp("frame_cnt_257", 1);
    push_exp("fs_wide", 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    p1 = -1; p2 = -1; first_ce = -1;
    pulses = 0; bad = 0; fcnt = -1;
    prev = 1'b0;
    for (int t = 1; t <= 6000; t++) begin
      @(negedge clk);
      if (ce_pix && first_ce < 0) first_ce = t;
      if (frame_start) begin
        if (prev) bad++;
        else begin
          pulses++;
          if (pulses == 1) p1 = t;
          if (pulses == 2) p2 = t;
          if (pulses == 257) begin
            fcnt = int'(frame_cnt);
            break;
          end
        end
      end
      prev = frame_start;
    end
    @(negedge clk);
    if (frame_start) bad++;
    sb_pop(first_ce);
    sb_pop(p1);
    sb_pop(p2 - p1);
    sb_pop(pulses);
    sb_pop(fcnt);
    sb_pop(bad);

    check("sb_left", sb_exp.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
